// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the EX hazard/forwarding controller
// Contents:
//   SB_RD_W          destination-register width carried by scoreboard entries
//   FWD_*            operand forward-select encodings
//   sb_entry_t       in-flight writer record {valid, wr, rd, load}
//   flush_state_t    flush FSM states (RUN, FLUSH)
package hazard_pkg;

    localparam int SB_RD_W = 6;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic               valid;
        logic               wr;
        logic [SB_RD_W-1:0] rd;
        logic               load;
    } sb_entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } flush_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - 3-deep EX/MEM/WB writer scoreboard with source-match outputs
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push_en, push_entry      entry entering EX this edge; bubble when push_en = 0
//   rs, rt, uses_rs, uses_rt sources of the instruction currently in ID
//   ex_hit_a/b               current EX entry writes the used rs/rt
//   mem_hit_a/b              current MEM entry writes the used rs/rt
//   ex_load_hit              EX entry is a load whose rd is a used source
//   wb_entry                 current WB entry (covered by the regfile bypass)
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_en,
    input  sb_entry_t          push_entry,
    input  logic [SB_RD_W-1:0] rs,
    input  logic [SB_RD_W-1:0] rt,
    input  logic               uses_rs,
    input  logic               uses_rt,
    output logic               ex_hit_a,
    output logic               ex_hit_b,
    output logic               mem_hit_a,
    output logic               mem_hit_b,
    output logic               ex_load_hit,
    output sb_entry_t          wb_entry
);

    sb_entry_t ex_entry;
    sb_entry_t mem_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_entry  <= '0;
            mem_entry <= '0;
            wb_entry  <= '0;
        end else begin
            wb_entry  <= mem_entry;
            mem_entry <= ex_entry;
            ex_entry  <= push_en ? push_entry : '0;
        end
    end

    logic ex_writes;
    logic mem_writes;

    assign ex_writes  = ex_entry.valid & ex_entry.wr;
    assign mem_writes = mem_entry.valid & mem_entry.wr;

    assign ex_hit_a  = ex_writes  & uses_rs & (ex_entry.rd  == rs);
    assign ex_hit_b  = ex_writes  & uses_rt & (ex_entry.rd  == rt);
    assign mem_hit_a = mem_writes & uses_rs & (mem_entry.rd == rs);
    assign mem_hit_b = mem_writes & uses_rt & (mem_entry.rd == rt);

    assign ex_load_hit = ex_entry.load & (ex_hit_a | ex_hit_b);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard, forwarding and flush controller
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_*                decoded fields of the instruction in ID
//   br_taken_ex         branch/jump in EX resolved taken this cycle
//   stall_o, flush_o    combinational IF/ID hold and ID kill
//   issue_ex            registered: valid instruction in EX
//   alu_src2_ex         registered: operand A is PC
//   fwd_a_ex, fwd_b_ex  registered: operand forward selects (00 reg, 01 MEM, 10 WB)
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = SB_RD_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              id_use_pc,
    input  logic              br_taken_ex,
    output logic              stall_o,
    output logic              flush_o,
    output logic              issue_ex,
    output logic              alu_src2_ex,
    output logic [1:0]        fwd_a_ex,
    output logic [1:0]        fwd_b_ex
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    flush_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic      ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, ex_load_hit;
    logic      issue;
    logic [1:0] fwd_a, fwd_b;
    sb_entry_t push_entry;

    assign push_entry = '{valid: 1'b1, wr: id_wr_en, rd: id_rd, load: id_is_load};

    hazard_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .push_en     (issue),
        .push_entry  (push_entry),
        .rs          (id_rs),
        .rt          (id_rt),
        .uses_rs     (id_uses_rs),
        .uses_rt     (id_uses_rt),
        .ex_hit_a    (ex_hit_a),
        .ex_hit_b    (ex_hit_b),
        .mem_hit_a   (mem_hit_a),
        .mem_hit_b   (mem_hit_b),
        .ex_load_hit (ex_load_hit),
        .wb_entry    ()
    );

    // Flush has priority: a wrong-path instruction must never hold the front end.
    assign flush_o = br_taken_ex | (state == FLUSH);
    assign stall_o = id_valid & ~flush_o & ex_load_hit;
    assign issue   = id_valid & ~stall_o & ~flush_o;

    // The EX producer will sit in MEM when this instruction reaches EX, hence
    // EX hit -> MEM result and MEM hit -> WB result. Nearest producer wins.
    assign fwd_a = id_use_pc ? FWD_REG :
                   ex_hit_a  ? FWD_MEM :
                   mem_hit_a ? FWD_WB  : FWD_REG;
    assign fwd_b = ex_hit_b  ? FWD_MEM :
                   mem_hit_b ? FWD_WB  : FWD_REG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Branches seen while in FLUSH are ignored: EX holds a bubble then.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                if (br_taken_ex && (FLUSH_CYCLES > 1)) begin
                    state_n = FLUSH;
                    cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_ex    <= 1'b0;
            alu_src2_ex <= 1'b0;
            fwd_a_ex    <= FWD_REG;
            fwd_b_ex    <= FWD_REG;
        end else begin
            issue_ex    <= issue;
            alu_src2_ex <= issue & id_use_pc;
            fwd_a_ex    <= issue ? fwd_a : FWD_REG;
            fwd_b_ex    <= issue ? fwd_b : FWD_REG;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - scoreboard testbench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

    localparam int AW = 6;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_use_pc, br_taken_ex;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          stall_o, flush_o, issue_ex, alu_src2_ex;
    logic [1:0]    fwd_a_ex, fwd_b_ex;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_wr_en    (id_wr_en),
        .id_is_load  (id_is_load),
        .id_use_pc   (id_use_pc),
        .br_taken_ex (br_taken_ex),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .issue_ex    (issue_ex),
        .alu_src2_ex (alu_src2_ex),
        .fwd_a_ex    (fwd_a_ex),
        .fwd_b_ex    (fwd_b_ex)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instructions in flight indexed by distance from ID
    // (0 = in EX, 1 = in MEM), plus remaining forced-flush cycles.
    logic          m_v[2];
    logic          m_wr[2];
    logic          m_ld[2];
    logic [AW-1:0] m_rd[2];
    int            flush_rem;

    // Expected {issue, alu_src2, fwd_a, fwd_b} after each edge.
    logic [5:0] exp_q[$];

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] src, input logic use_src);
        if (!use_src) return 2'd0;
        for (int d = 0; d < 2; d++) begin
            if (m_v[d] && m_wr[d] && m_rd[d] == src) return 2'(d + 1);
        end
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 0; m_wr[d] = 0; m_ld[d] = 0; m_rd[d] = '0;
        end
        flush_rem = 0;
    endtask

    task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic urs, input logic urt,
                        input logic wr, input logic ld, input logic pc, input logic br);
        logic e_flush, e_stall, haz, iss;
        logic [1:0] fa, fb;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_wr_en = wr; id_is_load = ld;
        id_use_pc = pc; br_taken_ex = br;

        e_flush = br || (flush_rem > 0);
        haz     = v && m_v[0] && m_wr[0] && m_ld[0] &&
                  ((urs && m_rd[0] == rs) || (urt && m_rd[0] == rt));
        e_stall = haz && !e_flush;
        iss     = v && !e_stall && !e_flush;
        fa      = pc ? 2'd0 : model_fwd(rs, urs);
        fb      = model_fwd(rt, urt);

        #1;
        check("stall_o", {7'd0, stall_o}, {7'd0, e_stall});
        check("flush_o", {7'd0, flush_o}, {7'd0, e_flush});
        exp_q.push_back({iss, iss & pc, iss ? fa : 2'd0, iss ? fb : 2'd0});

        m_v[1] = m_v[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0]; m_rd[1] = m_rd[0];
        m_v[0] = iss; m_wr[0] = iss & wr; m_ld[0] = iss & ld; m_rd[0] = rd;
        if (flush_rem > 0) flush_rem--;
        else if (br && FC > 1) flush_rem = FC - 1;
    endtask

    // Monitor: every edge the DUT presents a new EX select set.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("issue_ex",    {7'd0, issue_ex},    {7'd0, e[5]});
                check("alu_src2_ex", {7'd0, alu_src2_ex}, {7'd0, e[4]});
                check("fwd_a_ex",    {6'd0, fwd_a_ex},    {6'd0, e[3:2]});
                check("fwd_b_ex",    {6'd0, fwd_b_ex},    {6'd0, e[1:0]});
            end
        end
    end

    task automatic idle_inputs();
        id_valid = 0; id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_wr_en = 0; id_is_load = 0; id_use_pc = 0; br_taken_ex = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_issue"}, {7'd0, issue_ex}, 8'd0);
        check({tag, "_src2"},  {7'd0, alu_src2_ex}, 8'd0);
        check({tag, "_fwda"},  {6'd0, fwd_a_ex}, 8'd0);
        check({tag, "_fwdb"},  {6'd0, fwd_b_ex}, 8'd0);
        check({tag, "_stall"}, {7'd0, stall_o}, 8'd0);
        check({tag, "_flush"}, {7'd0, flush_o}, 8'd0);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // ADD r3, then SUB reading r3 in rs: EX->MEM forward
        step(1, 6'd1, 6'd2, 6'd3, 1, 1, 1, 0, 0, 0);
        step(1, 6'd3, 6'd4, 6'd6, 1, 1, 1, 0, 0, 0);
        // writer r5, unrelated, reader r5 in rt: WB forward
        step(1, 6'd0, 6'd0, 6'd5, 0, 0, 1, 0, 0, 0);
        step(1, 6'd10, 6'd11, 6'd12, 1, 1, 1, 0, 0, 0);
        step(1, 6'd13, 6'd5, 6'd14, 0, 1, 1, 0, 0, 0);
        // LD r7 then reader of r7: one stall, one bubble, then WB forward
        step(1, 6'd1, 6'd1, 6'd7, 0, 0, 1, 1, 0, 0);
        step(1, 6'd7, 6'd2, 6'd8, 1, 1, 1, 0, 0, 0);
        step(1, 6'd7, 6'd2, 6'd8, 1, 1, 1, 0, 0, 0);
        // taken branch pulse: two flush cycles
        step(1, 6'd1, 6'd2, 6'd15, 1, 1, 1, 0, 0, 1);
        step(1, 6'd1, 6'd2, 6'd16, 1, 1, 1, 0, 0, 0);
        step(1, 6'd1, 6'd2, 6'd17, 1, 1, 1, 0, 0, 0);
        // load-use coinciding with taken branch: flush wins
        step(1, 6'd0, 6'd0, 6'd9, 0, 0, 1, 1, 0, 0);
        step(1, 6'd9, 6'd9, 6'd18, 1, 1, 1, 0, 0, 1);
        step(1, 6'd9, 6'd9, 6'd18, 1, 1, 1, 0, 0, 0);
        step(1, 6'd9, 6'd9, 6'd18, 1, 1, 1, 0, 0, 0);
        // PC operand with rs matching the EX writer
        step(1, 6'd0, 6'd0, 6'd20, 0, 0, 1, 0, 0, 0);
        step(1, 6'd20, 6'd0, 6'd21, 1, 0, 1, 0, 1, 0);

        // asynchronous reset in the middle of a flush
        step(1, 6'd1, 6'd2, 6'd22, 1, 1, 1, 0, 0, 1);
        @(posedge clk);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_clear();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1, 6'd1, 6'd2, 6'd23, 1, 1, 1, 0, 0, 0);
        step(1, 6'd23, 6'd2, 6'd24, 1, 1, 1, 0, 0, 0);

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 7) != 0),
                 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        idle_inputs();
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Hazard and forwarding controller for the EX stage of the 5-stage pipeline.
- Tracks in-flight register writers in a 3-entry scoreboard (EX/MEM/WB).
- Produces registered select lines for the EX operand muxes: PC-vs-rs select plus forwarding selects.
- Stalls IF/ID on load-use hazards and flushes the wrong path after a taken branch resolved in EX.

Parameters:
REG_AW, 6, register-address width (64 architectural registers, all forwardable, none hardwired)
FLUSH_CYCLES, 2, number of cycles flush_o is held after a taken branch (>=1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  a valid instruction occupies ID
id_rs  in  REG_AW  source A register of the ID instruction
id_rt  in  REG_AW  source B register of the ID instruction
id_rd  in  REG_AW  destination register of the ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_wr_en  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a memory load
id_use_pc  in  1  operand A is PC rather than rs
br_taken_ex  in  1  branch/jump in EX resolved taken this cycle
stall_o  out  1  hold PC and IF/ID; combinational
flush_o  out  1  kill the ID instruction (bubble into EX); combinational
issue_ex  out  1  a valid instruction occupies EX; registered
alu_src2_ex  out  1  EX operand-A select: 0 = rs, 1 = PC; registered
fwd_a_ex  out  2  operand-A forward: 00 = regfile, 01 = MEM result, 10 = WB result; registered
fwd_b_ex  out  2  operand-B forward, same encoding; registered

Behaviour:
Reset
- rst asserted is asynchronous: all scoreboard entries invalid, FSM = RUN, flush count = 0.
- issue_ex, alu_src2_ex, fwd_a_ex, fwd_b_ex = 0.
- stall_o = 0 and flush_o = 0 as long as br_taken_ex = 0.
- Reset mid-flush or mid-stall discards all state; no deferred flush after reset release.

Scoreboard
- Entries are {valid, wr, rd, load}.
- Every rising edge: WB <= MEM, MEM <= EX.
- EX <= ID fields when id_valid & !stall_o & !flush_o, else EX <= bubble (valid = 0).

Forwarding (computed at ID, registered into EX alongside the instruction)
- Source A: match with current EX entry (valid & wr & rd == id_rs & id_uses_rs) gives 01. Otherwise a match with the current MEM entry gives 10. Otherwise 00.
- Nearest producer wins when both EX and MEM match.
- Source B: same rule using id_rt and id_uses_rt.
- Current WB entries are not forwarded; the regfile's write-then-read bypass covers them.
- id_use_pc = 1 forces fwd_a to 00 and alu_src2 to 1.
- When a bubble enters EX, issue_ex, alu_src2_ex and both fwd outputs are 0.

Load-use stall
- stall_o = id_valid & !flush_o & the EX entry is (valid & wr & load) & its rd matches a used source of the ID instruction.
- The stall lasts exactly one cycle: a bubble enters EX and the load moves to MEM.
- Next cycle the same ID instruction issues with fwd = 10.

Flush FSM: states RUN and FLUSH
- RUN: if br_taken_ex, go to FLUSH with cnt = FLUSH_CYCLES-1. If FLUSH_CYCLES = 1, stay in RUN.
- FLUSH: decrement cnt each cycle; return to RUN when cnt reaches 0 on that edge. br_taken_ex is ignored in FLUSH because EX holds a bubble.
- flush_o = br_taken_ex | (state == FLUSH).
- Simultaneous branch-taken and load-use: flush wins and stall_o = 0.

Latency
- Selects appear on the outputs one clock after the instruction sits in ID with stall_o = flush_o = 0.

Decomposition:
Shared package hazard_pkg holds:
- FWD_REG/FWD_MEM/FWD_WB encodings.
- Scoreboard-entry struct type.
- FSM state enum (RUN, FLUSH).

One sub-module is natural: hazard_scoreboard, the 3-deep entry shift register with bubble insert and match outputs. Compare logic, FSM and output registers stay in the top.

Test Plan:
- ADD r3 in ID, then SUB with rs = r3 next cycle -> SUB enters EX with fwd_a_ex = 01, fwd_b_ex = 00, stall_o never high.
- Writer of r5, one unrelated instruction, then a reader of r5 in rt -> reader enters EX with fwd_b_ex = 10.
- LD r7, then reader of r7 in rs -> stall_o = 1 for exactly 1 cycle, one bubble (issue_ex = 0), then reader issues with fwd_a_ex = 10.
- br_taken_ex pulse at cycle T with FLUSH_CYCLES = 2 -> flush_o high at T and T+1, issue_ex = 0 at T+1 and T+2, RUN at T+2.
- Load-use hazard coinciding with br_taken_ex -> stall_o = 0, flush_o = 1.
- id_use_pc = 1 with rs matching the EX writer -> alu_src2_ex = 1, fwd_a_ex = 00.
- rst asserted asynchronously mid-flush -> all outputs 0 immediately, no flush after release.
